vx_dcr_launcher: RTL and testbench

VX_DCR_LAUNCHER -- requirements
Module: VX_dcr_launcher

---
 rtl/vx_dcr_launcher.sv | 187 ++++++++++++++++++
 tb/tb_vx_dcr_launcher.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_dcr_launcher.sv
// DCR write launcher: queues host DCR writes, replays them to the core on start,
// then tracks the core's busy window and reports done, timeout error and run length.

`ifndef VX_DCR_ADDR_WIDTH
`define VX_DCR_ADDR_WIDTH 12
`endif
`ifndef VX_DCR_DATA_WIDTH
`define VX_DCR_DATA_WIDTH 32
`endif

// state      | meaning
// IDLE       | accepting cfg entries, waiting for start
// WRITE      | popping one queued entry per cycle onto the write port
// WAIT_BUSY  | last write issued, waiting (bounded) for busy to rise
// RUN        | core busy, counting busy cycles
// DONE       | one-cycle done pulse
module vx_dcr_launcher #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = `VX_DCR_ADDR_WIDTH,
    parameter int DATA_W  = `VX_DCR_DATA_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              cfg_ready,
    input  logic              start,
    output logic              write_valid,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    input  logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       run_cycles,
    output logic              launcher_busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int ENT_W = ADDR_W + DATA_W;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        WAIT_BUSY = 3'd2,
        RUN       = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               wv_q, wv_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               error_q, error_d;
    logic [31:0]        run_q, run_d;

    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [ENT_W-1:0]   rd_entry;
    logic               push;
    logic               pop;

    assign cfg_ready     = (state_q == IDLE) && (count_q < DEPTH_C);
    assign push          = cfg_valid && cfg_ready;
    assign rd_entry      = mem_q[rd_ptr_q];

    assign write_valid   = wv_q;
    assign write_addr    = waddr_q;
    assign write_data    = wdata_q;
    assign done          = (state_q == DONE);
    assign error         = error_q;
    assign run_cycles    = run_q;
    assign launcher_busy = (state_q != IDLE);

    // Storage only; occupancy lives in count_q so a reset discards the contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cfg_addr, cfg_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            timer_q  <= '0;
            wv_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            error_q  <= 1'b0;
            run_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            wv_q     <= wv_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            error_q  <= error_d;
            run_q    <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        error_d = error_q;
        run_d   = run_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    timer_d = '0;
                    state_d = ((count_q != '0) || push) ? WRITE : WAIT_BUSY;
                end
            end
            WRITE: begin
                pop = (count_q != '0);
                if (count_q <= CNT_W'(1)) begin
                    state_d = WAIT_BUSY;
                    timer_d = '0;
                end
            end
            WAIT_BUSY: begin
                // The final write is still on the port in the first cycle here,
                // so busy is not trusted until that strobe has gone out.
                if (busy && !wv_q) begin
                    state_d = RUN;
                    run_d   = 32'd1;
                end else if (timer_q == TMR_LAST) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            RUN: begin
                if (busy) begin
                    if (run_q != 32'hFFFF_FFFF) begin
                        run_d = run_q + 32'd1;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wv_d     = pop;
        waddr_d  = '0;
        wdata_d  = '0;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            waddr_d  = rd_entry[ENT_W-1:DATA_W];
            wdata_d  = rd_entry[DATA_W-1:0];
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

endmodule

// File: tb/tb_vx_dcr_launcher.sv
// Directed bench for vx_dcr_launcher: cycle-by-cycle vector table for normal launches,
// plus hand sequences for timeout, reset mid-write and a full FIFO.

module tb_vx_dcr_launcher;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;
    localparam int AW      = 12;
    localparam int DW      = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_valid;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          cfg_ready;
    logic          start;
    logic          write_valid;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic          busy;
    logic          done;
    logic          error;
    logic [31:0]   run_cycles;
    logic          launcher_busy;

    int n_tests = 0;
    int n_fail  = 0;

    vx_dcr_launcher #(
        .DEPTH   (DEPTH),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_valid     (cfg_valid),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .cfg_ready     (cfg_ready),
        .start         (start),
        .write_valid   (write_valid),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .run_cycles    (run_cycles),
        .launcher_busy (launcher_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          st;
        logic          bz;
        logic          e_wv;
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wd;
        logic          e_done;
        logic          e_err;
        logic          e_lb;
        logic          e_rdy;
        logic [31:0]   e_run;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic st, input logic bz,
                                input logic e_wv, input logic [AW-1:0] e_wa, input logic [DW-1:0] e_wd,
                                input logic e_done, input logic e_err, input logic e_lb,
                                input logic e_rdy, input logic [31:0] e_run);
        vec_t r;
        r.v = v; r.a = a; r.d = d; r.st = st; r.bz = bz;
        r.e_wv = e_wv; r.e_wa = e_wa; r.e_wd = e_wd;
        r.e_done = e_done; r.e_err = e_err; r.e_lb = e_lb; r.e_rdy = e_rdy; r.e_run = e_run;
        vecs.push_back(r);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_valid = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        start     = 1'b0;
        busy      = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " write_valid"},   32'(write_valid),   32'd0);
        chk({tag, " write_addr"},    32'(write_addr),    32'd0);
        chk({tag, " write_data"},    write_data,         32'd0);
        chk({tag, " done"},          32'(done),          32'd0);
        chk({tag, " error"},         32'(error),         32'd0);
        chk({tag, " run_cycles"},    run_cycles,         32'd0);
        chk({tag, " launcher_busy"}, 32'(launcher_busy), 32'd0);
        chk({tag, " cfg_ready"},     32'(cfg_ready),     32'd1);
    endtask

    initial begin
        int n;
        int k;
        logic seen_done;
        logic seen_wv;

        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        chk_reset_outputs("reset");
        reset = 1'b0;

        // launch of 3 entries, busy 2 cycles after last write for 10 cycles
        add(1, 12'h001, 32'hA, 0, 0,  0, 0, 0,             0, 0, 0, 1, 0);
        add(1, 12'h002, 32'hB, 0, 0,  0, 0, 0,             0, 0, 0, 1, 0);
        add(1, 12'h003, 32'hC, 0, 0,  0, 0, 0,             0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0,            0, 0, 0,             0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0,            1, 12'h001, 32'hA,   0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0,            1, 12'h002, 32'hB,   0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0,            1, 12'h003, 32'hC,   0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0,            0, 0, 0,             0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0,            0, 0, 0,             0, 0, 1, 0, 0);
        for (int i = 1; i <= 10; i++)
            add(0, 0, 0, (i == 5), 1, 0, 0, 0,             0, 0, 1, 0, 32'(i));
        add(0, 0, 0, 0, 0,            0, 0, 0,             1, 0, 1, 0, 10);
        add(0, 0, 0, 0, 0,            0, 0, 0,             0, 0, 0, 1, 10);
        // empty start, busy 4 cycles; busy during DONE is ignored
        add(0, 0, 0, 1, 0,            0, 0, 0,             0, 0, 1, 0, 10);
        for (int i = 1; i <= 4; i++)
            add(0, 0, 0, 0, 1,        0, 0, 0,             0, 0, 1, 0, 32'(i));
        add(0, 0, 0, 0, 0,            0, 0, 0,             1, 0, 1, 0, 4);
        add(0, 0, 0, 0, 1,            0, 0, 0,             0, 0, 0, 1, 4);
        // push and start together; busy ignored in IDLE/WRITE and while last write pending
        add(1, 12'h055, 32'h1234, 1, 1, 0, 0, 0,           0, 0, 1, 0, 4);
        add(0, 0, 0, 0, 1,            1, 12'h055, 32'h1234, 0, 0, 1, 0, 4);
        add(0, 0, 0, 0, 1,            0, 0, 0,             0, 0, 1, 0, 4);
        add(0, 0, 0, 0, 1,            0, 0, 0,             0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0,            0, 0, 0,             1, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0,            0, 0, 0,             0, 0, 0, 1, 1);

        foreach (vecs[i]) begin
            cfg_valid = vecs[i].v;
            cfg_addr  = vecs[i].a;
            cfg_data  = vecs[i].d;
            start     = vecs[i].st;
            busy      = vecs[i].bz;
            tick();
            chk($sformatf("vec%0d write_valid", i),   32'(write_valid),   32'(vecs[i].e_wv));
            chk($sformatf("vec%0d write_addr", i),    32'(write_addr),    32'(vecs[i].e_wa));
            chk($sformatf("vec%0d write_data", i),    write_data,         vecs[i].e_wd);
            chk($sformatf("vec%0d done", i),          32'(done),          32'(vecs[i].e_done));
            chk($sformatf("vec%0d error", i),         32'(error),         32'(vecs[i].e_err));
            chk($sformatf("vec%0d launcher_busy", i), 32'(launcher_busy), 32'(vecs[i].e_lb));
            chk($sformatf("vec%0d cfg_ready", i),     32'(cfg_ready),     32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d run_cycles", i),    run_cycles,         vecs[i].e_run);
        end
        idle_inputs();

        // timeout with one entry: WRITE (1 cycle) + WAIT_BUSY (TIMEOUT cycles)
        cfg_valid = 1'b1; cfg_addr = 12'h0AA; cfg_data = 32'h77;
        tick();
        idle_inputs();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("timeout start launcher_busy", 32'(launcher_busy), 32'd1);
        n = 1;
        seen_done = 1'b0;
        for (int c = 0; c < TIMEOUT + 20 && launcher_busy; c++) begin
            tick();
            if (done) seen_done = 1'b1;
            if (launcher_busy) n++;
        end
        chk("timeout busy cycles", 32'(n), 32'(TIMEOUT + 1));
        chk("timeout launcher_busy", 32'(launcher_busy), 32'd0);
        chk("timeout error", 32'(error), 32'd1);
        chk("timeout no done", 32'(seen_done), 32'd0);
        chk("timeout run_cycles kept", run_cycles, 32'd1);

        // error sticky through pushes, cleared by start; then reset during 2nd of 4 writes
        for (int i = 0; i < 4; i++) begin
            cfg_valid = 1'b1; cfg_addr = 12'(12'h100 + i); cfg_data = 32'(32'h200 + i);
            tick();
        end
        idle_inputs();
        chk("error sticky", 32'(error), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start clears error", 32'(error), 32'd0);
        tick();
        chk("rst seq write1 addr", 32'(write_addr), 32'h100);
        tick();
        chk("rst seq write2 valid", 32'(write_valid), 32'd1);
        chk("rst seq write2 addr", 32'(write_addr), 32'h101);
        reset = 1'b1;
        tick();
        chk_reset_outputs("midreset");
        reset = 1'b0;
        seen_wv = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (write_valid) seen_wv = 1'b1;
        end
        chk("midreset no writes after", 32'(seen_wv), 32'd0);
        chk("midreset stays idle", 32'(launcher_busy), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("midreset fifo empty launch", 32'(launcher_busy), 32'd1);
        for (int c = 0; c < 4; c++) begin
            tick();
            if (write_valid) seen_wv = 1'b1;
        end
        chk("midreset queue discarded", 32'(seen_wv), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // full FIFO: DEPTH+1 offers with cfg_valid held
        cfg_valid = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            cfg_addr = 12'(12'h010 + i);
            cfg_data = 32'(32'hD0 + i);
            chk($sformatf("full ready offer%0d", i), 32'(cfg_ready), 32'(i < DEPTH));
            tick();
        end
        idle_inputs();
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        for (int c = 0; c < DEPTH + 4; c++) begin
            tick();
            if (write_valid) begin
                chk($sformatf("full write%0d addr", k), 32'(write_addr), 32'(12'h010 + k));
                chk($sformatf("full write%0d data", k), write_data, 32'(32'hD0 + k));
                k++;
            end
        end
        chk("full write count", 32'(k), 32'(DEPTH));
        reset = 1'b1;
        tick();
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
